// File: rtl/gfx_wbm_read_arbiter.sv
// rtl/gfx_wbm_read_arbiter.sv - round-robin Wishbone read master for blend/tex/z requesters
module gfx_wbm_read_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        blend_request_i,
    input  logic [31:2] blend_addr_i,
    input  logic [3:0]  blend_sel_i,
    output logic        blend_ack_o,
    input  logic        tex_request_i,
    input  logic [31:2] tex_addr_i,
    input  logic [3:0]  tex_sel_i,
    output logic        tex_ack_o,
    input  logic        z_request_i,
    input  logic [31:2] z_addr_i,
    input  logic [3:0]  z_sel_i,
    output logic        z_ack_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [2:0]  m_cti_o,
    output logic [1:0]  m_bte_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_sel_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant;
    logic [1:0]  rr_ptr;
    logic [1:0]  pick;
    logic        pick_valid;
    logic        err_q;
    logic [3:0]  req;
    logic [29:0] pick_addr;
    logic [3:0]  pick_sel;
    logic        bus_done;

    assign req      = {1'b0, z_request_i, tex_request_i, blend_request_i};
    assign bus_done = m_ack_i | m_err_i;

    // Scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first requester found wins.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        pick_valid = 1'b0;
        pick       = 2'd0;
        sum        = 3'd0;
        idx        = 2'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd1:    begin pick_addr = tex_addr_i; pick_sel = tex_sel_i; end
            2'd2:    begin pick_addr = z_addr_i;   pick_sel = z_sel_i;   end
            default: begin pick_addr = blend_addr_i; pick_sel = blend_sel_i; end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = READ;
            READ:    if (bus_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus address/select are captured at grant so later requester changes cannot disturb the cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant   <= 2'd0;
            rr_ptr  <= 2'd0;
            m_adr_o <= 32'h0;
            m_sel_o <= 4'hF;
            data_o  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant   <= pick;
                m_adr_o <= {pick_addr, 2'b00};
                m_sel_o <= pick_sel;
            end
            if (state == READ && bus_done) begin
                data_o <= m_err_i ? 32'h0 : m_dat_i;
                err_q  <= m_err_i;
                rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
            end
        end
    end

    always_comb begin
        busy_o      = (state != IDLE);
        m_cyc_o     = (state == READ);
        m_stb_o     = (state == READ);
        m_we_o      = 1'b0;
        m_cti_o     = 3'b000;
        m_bte_o     = 2'b00;
        blend_ack_o = (state == DONE) && (grant == 2'd0);
        tex_ack_o   = (state == DONE) && (grant == 2'd1);
        z_ack_o     = (state == DONE) && (grant == 2'd2);
        err_o       = (state == DONE) && err_q;
    end

endmodule
